// File: rtl/seg_scan_mux.sv
// Scan driver for an eight-digit seven-segment display: frame snapshot,
// programmable digit rate, leading-zero/blank/DP handling, registered outputs.
module seg_scan_mux #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic        lz_en,
  output logic [7:0]  anode,
  output logic [3:0]  display_bcd,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic [7:0]    dp_snap;
  logic [7:0]    blk_snap;
  logic          lz_snap;

  logic          tick;
  logic          wrap;
  logic [2:0]    idx_nxt;
  logic [31:0]   snap_nxt;
  logic [7:0]    dp_nxt;
  logic [7:0]    blk_nxt;
  logic          lz_nxt;
  logic [7:0]    nz_above;
  logic          slot_dark;

  assign tick     = (presc == PRESC_MAX) && enable;
  assign wrap     = tick && (idx == 3'd7);
  assign idx_nxt  = tick ? idx + 3'd1 : idx;
  // Outputs on the wrap edge must reflect the frame being loaded, not the old one.
  assign snap_nxt = wrap ? digits     : snap;
  assign dp_nxt   = wrap ? dp_mask    : dp_snap;
  assign blk_nxt  = wrap ? blank_mask : blk_snap;
  assign lz_nxt   = wrap ? lz_en      : lz_snap;

  // nz_above[i] is set when any nibble at position i or higher is non-zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    logic acc;
    acc      = 1'b0;
    nz_above = '0;
    for (int i = 7; i >= 0; i--) begin
      acc         = acc | (snap_nxt[4*i +: 4] != 4'd0);
      nz_above[i] = acc;
    end
  end

  assign slot_dark = blk_nxt[idx_nxt] ||
                     (lz_nxt && (idx_nxt != 3'd0) && !nz_above[idx_nxt]);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      idx      <= 3'd7;
      snap     <= '0;
      dp_snap  <= '0;
      blk_snap <= '0;
      lz_snap  <= 1'b0;
    end else begin
      if (enable) presc <= tick ? '0 : presc + 1'b1;
      idx      <= idx_nxt;
      snap     <= snap_nxt;
      dp_snap  <= dp_nxt;
      blk_snap <= blk_nxt;
      lz_snap  <= lz_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode       <= 8'hFF;
      display_bcd <= 4'hF;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (!enable || (tick && slot_dark)) begin
        anode       <= 8'hFF;
        display_bcd <= 4'hF;
        dp_n        <= 1'b1;
      end else if (tick) begin
        anode       <= ~(8'b1 << idx_nxt);
        display_bcd <= snap_nxt[4*idx_nxt +: 4];
        dp_n        <= ~dp_nxt[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: scenario table, hand-written corner sequences and
// randomized stimulus compared against a frame-level reference model.
module tb_seg_scan_mux;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic        lz_en;
  logic [7:0]  anode;
  logic [3:0]  display_bcd;
  logic        dp_n;
  logic        frame_done;

  seg_scan_mux #(.TICK_DIV(T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_en(lz_en),
    .anode(anode), .display_bcd(display_bcd), .dp_n(dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: counts enabled edges; every T-th one starts a new slot.
  int         en_cnt;
  logic [3:0] m_snap [8];
  logic [7:0] m_dp, m_blk;
  logic       m_lz;
  logic [7:0] e_anode;
  logic [3:0] e_bcd;
  logic       e_dpn, e_fd;

  task automatic model_reset();
    en_cnt = 0;
    for (int i = 0; i < 8; i++) m_snap[i] = 4'd0;
    m_dp = '0; m_blk = '0; m_lz = 1'b0;
    e_anode = 8'hFF; e_bcd = 4'hF; e_dpn = 1'b1; e_fd = 1'b0;
  endtask

  task automatic model_edge();
    int  k;
    bit  upper_nz;
    e_fd = 1'b0;
    if (!enable) begin
      e_anode = 8'hFF; e_bcd = 4'hF; e_dpn = 1'b1;
      return;
    end
    en_cnt++;
    if (en_cnt % T != 0) return;
    k = ((en_cnt / T) - 1) % 8;
    if (k == 0) begin
      for (int i = 0; i < 8; i++) m_snap[i] = digits[4*i +: 4];
      m_dp = dp_mask; m_blk = blank_mask; m_lz = lz_en;
      e_fd = 1'b1;
    end
    upper_nz = 0;
    for (int j = k; j < 8; j++) if (m_snap[j] != 0) upper_nz = 1;
    if (m_blk[k] || (m_lz && k != 0 && !upper_nz)) begin
      e_anode = 8'hFF; e_bcd = 4'hF; e_dpn = 1'b1;
    end else begin
      e_anode = 8'hFF ^ (8'd1 << k);
      e_bcd   = m_snap[k];
      e_dpn   = !m_dp[k];
    end
  endtask

  // One clock: advance model with the inputs the DUT will see, sample at negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("model_anode", anode, e_anode);
    check("model_bcd", display_bcd, e_bcd);
    check("model_dpn", dp_n, e_dpn);
    check("model_fd", frame_done, e_fd);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fd(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (frame_done) seen = 1;
    end
    if (!seen) check("wait_fd_timeout", 0, 1);
  endtask

  task automatic set_inputs(input logic [31:0] d, input logic [7:0] dp,
                            input logic [7:0] blk, input logic lz);
    digits = d; dp_mask = dp; blank_mask = blk; lz_en = lz;
  endtask

  // From reset release: 4 dark samples, 8 digits of T cycles, then wrap again.
  task automatic first_frame();
    for (int i = 0; i < T; i++) begin
      check("ff_dark_anode", anode, 8'hFF);
      check("ff_dark_fd", frame_done, 0);
      step();
    end
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < T; c++) begin
        check("ff_anode", anode, 8'hFF ^ (8'd1 << (s % 8)));
        check("ff_bcd", display_bcd, 32'((s % 8) + 1));
        check("ff_fd", frame_done, (c == 0 && (s == 0 || s == 8)) ? 1 : 0);
        step();
      end
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  blk;
    logic        lz;
    logic [7:0]  lit;
    logic [31:0] bcd;
    logic [7:0]  dpn;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h87654321, 8'h00, 8'h00, 1'b0, 8'hFF, 32'h87654321, 8'hFF};
    vecs[1] = '{32'h00000305, 8'h00, 8'h00, 1'b1, 8'h07, 32'hFFFFF305, 8'hFF};
    vecs[2] = '{32'h00000000, 8'h00, 8'h00, 1'b1, 8'h01, 32'hFFFFFFF0, 8'hFF};
    vecs[3] = '{32'h87654321, 8'h04, 8'h06, 1'b0, 8'hF9, 32'h87654FF1, 8'hFF};
    vecs[4] = '{32'h87654321, 8'h04, 8'h00, 1'b0, 8'hFF, 32'h87654321, 8'hFB};
    vecs[5] = '{32'hFEDCBA98, 8'h81, 8'h00, 1'b1, 8'hFF, 32'hFEDCBA98, 8'h7E};

    reset = 1'b1; enable = 1'b1;
    set_inputs(32'h87654321, 8'h00, 8'h00, 1'b0);
    model_reset();
    @(negedge clk);
    check("rst_anode", anode, 8'hFF);
    check("rst_bcd", display_bcd, 4'hF);
    check("rst_dpn", dp_n, 1);
    check("rst_fd", frame_done, 0);
    reset = 1'b0;
    first_frame();

    // Scenario table: load at a wrap, then check each digit slot.
    for (int v = 0; v < 6; v++) begin
      set_inputs(vecs[v].d, vecs[v].dp, vecs[v].blk, vecs[v].lz);
      wait_fd(10 * T);
      for (int s = 0; s < 8; s++) begin
        check($sformatf("v%0d_s%0d_anode", v, s), anode,
              vecs[v].lit[s] ? (8'hFF ^ (8'd1 << s)) : 8'hFF);
        check($sformatf("v%0d_s%0d_bcd", v, s), display_bcd, vecs[v].bcd[4*s +: 4]);
        check($sformatf("v%0d_s%0d_dpn", v, s), dp_n, vecs[v].dpn[s]);
        steps(T);
      end
    end

    // Snapshot coherence: clearing digits mid-frame only shows after the wrap.
    set_inputs(32'h87654321, 8'h00, 8'h00, 1'b0);
    wait_fd(10 * T);
    wait_fd(10 * T);
    steps(3 * T);
    check("coh_d3_anode", anode, 8'hF7);
    digits = 32'h0;
    for (int s = 4; s < 8; s++) begin
      steps(T);
      check("coh_anode", anode, 8'hFF ^ (8'd1 << s));
      check("coh_old_bcd", display_bcd, 32'(s + 1));
    end
    steps(T);
    check("coh_wrap_fd", frame_done, 1);
    check("coh_wrap_bcd", display_bcd, 4'h0);
    steps(3 * T);
    check("coh_new_d3_bcd", display_bcd, 4'h0);

    // Enable pause during digit 5.
    digits = 32'h87654321;
    wait_fd(10 * T);
    wait_fd(10 * T);
    steps(5 * T + 1);
    check("pause_d5_lit", anode, 8'hDF);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_dark", anode, 8'hFF);
      check("pause_fd", frame_done, 0);
    end
    enable = 1'b1;
    steps(2);
    check("resume_still_dark", anode, 8'hFF);
    step();
    check("resume_d6_anode", anode, 8'hBF);
    check("resume_d6_bcd", display_bcd, 4'h7);

    // Asynchronous reset between edges while digit 4 is lit.
    wait_fd(10 * T);
    steps(4 * T + 1);
    check("areset_d4_lit", anode, 8'hEF);
    #2 reset = 1'b1;
    #1;
    check("areset_anode", anode, 8'hFF);
    check("areset_bcd", display_bcd, 4'hF);
    check("areset_dpn", dp_n, 1);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    first_frame();

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7, 0) == 0) begin
        logic [31:0] d;
        for (int i = 0; i < 8; i++)
          d[4*i +: 4] = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 0));
        set_inputs(d, 8'($urandom), ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00,
                   1'($urandom));
      end
      enable = ($urandom_range(9, 0) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
